seq_det_param: RTL and testbench
================================

# seq_det_param

Parametrised serial sequence detector: samples one bit per enabled clock on `DIN`, compares a sliding history window against a run-time programmable pattern with per-bit don't-care mask, and pulses `SOUT` on each match. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It is the generalised successor of the fixed 8-bit (11010011) serial checker and is used wherever the design needs frame or sync-word detection on a serial stream.

## Interface
- `W`, 8: history/pattern width in bits (2..32)
- `CW`, 8: match counter width
- `DEF_PAT`, 8'b11010011: pattern loaded at reset (width `W`)
- `DEF_MASK`, all ones: mask loaded at reset (width `W`)

Ports:
- `CLK`  in  1  clock, all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `EN`  in  1  `DIN` is valid this cycle
- `DIN`  in  1  serial data bit
- `OVL`  in  1  1 = overlapping detection, 0 = non-overlapping
- `LOAD`  in  1  capture `PAT_IN`/`MASK_IN`
- `PAT_IN`  in  W  new pattern; bit 0 = most recent bit, bit W-1 = oldest
- `MASK_IN`  in  W  1 = compare this bit, 0 = don't care
- `CLR_CNT`  in  1  clear match counter
- `SOUT`  out  1  registered one-cycle match pulse
- `MCNT`  out  CW  saturating match count

## Operation
- State: `hist[W-1:0]` (shift register), `fill` (0..W, saturating count of valid bits in `hist`), `pat`, `mask`, `MCNT`, `SOUT`.
- Reset: `hist`=0, `fill`=0, `pat`=`DEF_PAT`, `mask`=`DEF_MASK`, `SOUT`=0, `MCNT`=0.
- Shift: on `EN`=1, `hist <= {hist[W-2:0], DIN}`, `fill <= min(fill+1, W)`.
- Match condition, evaluated on the post-shift window (the new bit included): for every i with `mask[i]`=1, i < fill+1 (bit present) and window[i]==`pat[i]`; `mask`=0 never matches.
- On match: `SOUT`=1 next cycle. If `MCNT` < 2^CW-1 then `MCNT`+1, otherwise hold.
- On match with `OVL`=0, `fill` is set to 0, so the next match needs a fully fresh window. With `OVL`=1, `fill` updates normally.
- `SOUT` is 0 in every cycle that does not follow a matching `EN` edge. `EN`=0 holds `hist`, `fill` and `pat`.
- `LOAD`=1 (priority over `EN`): capture `pat`/`mask`, clear `hist` and `fill`, force `SOUT`=0. A `DIN` presented in the same cycle is discarded. `MCNT` is unaffected.
- `CLR_CNT`=1: `MCNT`=0. If a match occurs in the same cycle, `MCNT`=1.
- Priority: `RST` > `LOAD` > `EN`. `CLR_CNT` is independent of `LOAD`.

## Timing
- Latency: the bit completing a pattern is sampled at edge N; `SOUT`=1 for the cycle after edge N, low again after edge N+1 unless the next bit also matches.
- Back-to-back matches (e.g. pattern all ones, `OVL`=1) produce `SOUT` high on consecutive cycles.
- `MCNT` updates on the same edge that raises `SOUT`.
- `RST` asserted mid-stream clears everything at the next edge; the first match after reset needs a full masked window of new bits.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `seq_det_pkg`: `DEF_PAT` constant 8'b11010011, default widths, and a `sat_inc` function for the counter.
- One sub-module, `seq_win_cmp`: a combinational masked compare of window, `pat`, `mask` and `fill` producing `hit`. Everything else stays in the top level.

## Test plan
- Reset defaults: stream `1,1,0,1,0,0,1,1` with `EN`=1 → `SOUT` pulses once, the cycle after the 8th bit; `MCNT`=1.
- Overlap: `LOAD` `pat`=8'h0B, `mask`=8'h0F (pattern 1011). Stream `1,0,1,1,0,1,1` with `OVL`=1 → 2 pulses (after bits 4 and 7). With `OVL`=0 → 1 pulse (after bit 4).
- Gaps: default pattern with `EN` low for 3 cycles between bits 4 and 5 → single pulse after bit 8. `SOUT` and `hist` are unchanged during the gaps.
- Load mid-stream: 6 bits of the default pattern, then `LOAD` with the same `pat`, then the remaining 2 bits → no pulse. The full 8 bits after that → 1 pulse.
- Saturation and clear: `CW`=2, pattern all-ones, `OVL`=1, 6 ones after fill → `MCNT` stops at 3. `CLR_CNT` together with a match → `MCNT`=1.
- Edge cases: `mask`=0 with 20 random bits → never pulses. `RST` during an almost-complete pattern → no pulse and `MCNT`=0.

Source files
------------

// File: rtl/seq_det_param_pkg.sv
// seq_det_param shared package
// Default sizing, reset pattern and counter helper.
package seq_det_pkg;

    localparam int DEF_W = 8;
    localparam int DEF_CW = 8;
    localparam logic [7:0] DEF_PAT = 8'b11010011;

    // Counter width is a run-time argument so one helper serves any CW.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned cw
    );
        logic [31:0] max;
        max = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_det_param_if.sv
// seq_det_param stream/control bundle
// Master drives stream and control, slave returns match outputs.
interface seq_det_param_if
    import seq_det_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int CW = DEF_CW
);

    logic          EN;
    logic          DIN;
    logic          OVL;
    logic          LOAD;
    logic [W-1:0]  PAT_IN;
    logic [W-1:0]  MASK_IN;
    logic          CLR_CNT;
    logic          SOUT;
    logic [CW-1:0] MCNT;

    modport master (
        output EN, DIN, OVL, LOAD,
        output PAT_IN, MASK_IN, CLR_CNT,
        input  SOUT, MCNT
    );

    modport slave (
        input  EN, DIN, OVL, LOAD,
        input  PAT_IN, MASK_IN, CLR_CNT,
        output SOUT, MCNT
    );

endinterface

// File: rtl/seq_det_param_win_cmp.sv
// seq_win_cmp: masked window compare
// A masked bit only counts when it holds a real sample.
module seq_win_cmp #(
    parameter int W = seq_det_pkg::DEF_W,
    parameter int FW = 4
) (
    input  logic [W-1:0]  win,
    input  logic [W-1:0]  pat,
    input  logic [W-1:0]  mask,
    input  logic [FW-1:0] fill,
    output logic          hit
);

    logic [W-1:0] vld;

    always_comb begin
        vld = '0;
        for (int i = 0; i < W; i++) begin
            vld[i] = (i < int'(fill));
        end
        hit = (|mask)
            && ~|(mask & ~vld)
            && ~|((win ^ pat) & mask);
    end

endmodule

// File: rtl/seq_det_param.sv
// seq_det_param: programmable serial sequence detector
// Sliding window, masked pattern, saturating match count.
module seq_det_param #(
    parameter int W = seq_det_pkg::DEF_W,
    parameter int CW = seq_det_pkg::DEF_CW,
    parameter logic [W-1:0] DEF_PAT =
        W'(seq_det_pkg::DEF_PAT),
    parameter logic [W-1:0] DEF_MASK = '1
) (
    input logic             CLK,
    input logic             RST,
    seq_det_param_if.slave  bus
);

    import seq_det_pkg::*;

    localparam int FW = $clog2(W + 1);

    logic [W-1:0]  hist;
    logic [W-1:0]  pat;
    logic [W-1:0]  mask;
    logic [W-1:0]  win;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_n;
    logic          hit;
    logic          match;
    logic          sout;
    logic [CW-1:0] mcnt;

    assign win = {hist[W-2:0], bus.DIN};

    assign fill_n = (fill == FW'(W))
                  ? fill
                  : fill + FW'(1);

    assign match = bus.EN && !bus.LOAD && hit;

    seq_win_cmp #(
        .W  (W),
        .FW (FW)
    ) u_cmp (
        .win  (win),
        .pat  (pat),
        .mask (mask),
        .fill (fill_n),
        .hit  (hit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            hist <= '0;
            fill <= '0;
            pat  <= DEF_PAT;
            mask <= DEF_MASK;
            sout <= 1'b0;
            mcnt <= '0;
        end else begin
            sout <= 1'b0;
            if (bus.LOAD) begin
                pat  <= bus.PAT_IN;
                mask <= bus.MASK_IN;
                hist <= '0;
                fill <= '0;
            end else if (bus.EN) begin
                hist <= win;
                // Non-overlap: restart the window after a hit
                fill <= (hit && !bus.OVL) ? '0 : fill_n;
                sout <= hit;
            end
            if (bus.CLR_CNT) begin
                mcnt <= match ? CW'(1) : '0;
            end else if (match) begin
                mcnt <= CW'(sat_inc(32'(mcnt), CW));
            end
        end
    end

    assign bus.SOUT = sout;
    assign bus.MCNT = mcnt;

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: directed checks of seq_det_param
// Two instances: default widths and a 2-bit counter.
module tb_seq_det_param;

    logic CLK;
    logic RST;
    int   n_chk;
    int   n_fail;

    seq_det_param_if #(.W(8), .CW(8)) bus ();
    seq_det_param_if #(.W(8), .CW(2)) bus2 ();

    seq_det_param #(.W(8), .CW(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    seq_det_param #(.W(8), .CW(2)) dut2 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus2.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        n_chk++;
        if (bus.SOUT !== 1'b0 || bus.MCNT !== 8'd0) begin
            n_fail++;
            $display("FAIL reset: SOUT=%0b MCNT=%0d want 0 0",
                     bus.SOUT, bus.MCNT);
        end
        n_chk++;
        if (bus2.SOUT !== 1'b0 || bus2.MCNT !== 2'd0) begin
            n_fail++;
            $display("FAIL reset2: SOUT=%0b MCNT=%0d want 0 0",
                     bus2.SOUT, bus2.MCNT);
        end
        n_chk++;
        if (dut.hist !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hist: got %h want 00", dut.hist);
        end
        RST = 1'b0;
    endtask

    task automatic test_default();
        logic [7:0] s;
        s = 8'hD3;
        bus.OVL = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bus.EN  = 1'b1;
            bus.DIN = s[i];
            tick();
            n_chk++;
            if (bus.SOUT !== (i == 0)) begin
                n_fail++;
                $display("FAIL default bit%0d: SOUT=%0b want %0b",
                         8 - i, bus.SOUT, (i == 0));
            end
        end
        bus.EN = 1'b0;
        tick();
        n_chk++;
        if (bus.SOUT !== 1'b0 || bus.MCNT !== 8'd1) begin
            n_fail++;
            $display("FAIL default_end: SOUT=%0b MCNT=%0d want 0 1",
                     bus.SOUT, bus.MCNT);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] s;
        s = 8'hD3;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 7; i >= 4; i--) begin
            bus.EN  = 1'b1;
            bus.DIN = s[i];
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            bus.EN  = 1'b0;
            bus.DIN = g[0];
            tick();
            n_chk++;
            if (bus.SOUT !== 1'b0 || dut.hist !== 8'h0D) begin
                n_fail++;
                $display("FAIL gap%0d: SOUT=%0b hist=%h want 0 0d",
                         g, bus.SOUT, dut.hist);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            bus.EN  = 1'b1;
            bus.DIN = s[i];
            tick();
            n_chk++;
            if (bus.SOUT !== (i == 0)) begin
                n_fail++;
                $display("FAIL gaps bit%0d: SOUT=%0b want %0b",
                         8 - i, bus.SOUT, (i == 0));
            end
        end
        bus.EN = 1'b0;
        n_chk++;
        if (bus.MCNT !== 8'd1) begin
            n_fail++;
            $display("FAIL gaps_cnt: MCNT=%0d want 1", bus.MCNT);
        end
    endtask

    task automatic test_load_mid();
        logic [7:0] s;
        s = 8'hD3;
        for (int i = 7; i >= 2; i--) begin
            bus.EN  = 1'b1;
            bus.DIN = s[i];
            tick();
        end
        bus.LOAD    = 1'b1;
        bus.PAT_IN  = 8'hD3;
        bus.MASK_IN = 8'hFF;
        bus.DIN     = 1'b1;
        tick();
        bus.LOAD = 1'b0;
        n_chk++;
        if (bus.SOUT !== 1'b0 || dut.hist !== 8'h00) begin
            n_fail++;
            $display("FAIL load: SOUT=%0b hist=%h want 0 00",
                     bus.SOUT, dut.hist);
        end
        for (int i = 1; i >= 0; i--) begin
            bus.DIN = s[i];
            tick();
            n_chk++;
            if (bus.SOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL load_tail bit%0d: SOUT=%0b want 0",
                         i, bus.SOUT);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            bus.DIN = s[i];
            tick();
            n_chk++;
            if (bus.SOUT !== (i == 0)) begin
                n_fail++;
                $display("FAIL load_full bit%0d: SOUT=%0b want %0b",
                         8 - i, bus.SOUT, (i == 0));
            end
        end
        bus.EN = 1'b0;
        n_chk++;
        if (bus.MCNT !== 8'd2) begin
            n_fail++;
            $display("FAIL load_cnt: MCNT=%0d want 2", bus.MCNT);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e;
        s = 7'b1011011;
        for (int m = 1; m >= 0; m--) begin
            e = (m == 1) ? 7'b0001001 : 7'b0001000;
            bus.LOAD    = 1'b1;
            bus.EN      = 1'b0;
            bus.PAT_IN  = 8'h0B;
            bus.MASK_IN = 8'h0F;
            tick();
            bus.LOAD = 1'b0;
            bus.OVL  = m[0];
            for (int i = 6; i >= 0; i--) begin
                bus.EN  = 1'b1;
                bus.DIN = s[i];
                tick();
                n_chk++;
                if (bus.SOUT !== e[i]) begin
                    n_fail++;
                    $display("FAIL ovl%0d bit%0d: SOUT=%0b want %0b",
                             m, 7 - i, bus.SOUT, e[i]);
                end
            end
            bus.EN = 1'b0;
        end
        bus.OVL = 1'b1;
        n_chk++;
        if (bus.MCNT !== 8'd5) begin
            n_fail++;
            $display("FAIL ovl_cnt: MCNT=%0d want 5", bus.MCNT);
        end
    endtask

    task automatic test_mask_zero();
        bus.LOAD    = 1'b1;
        bus.PAT_IN  = 8'($urandom);
        bus.MASK_IN = 8'h00;
        tick();
        bus.LOAD = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.EN  = 1'b1;
            bus.DIN = 1'($urandom_range(0, 1));
            tick();
            n_chk++;
            if (bus.SOUT !== 1'b0) begin
                n_fail++;
                $display("FAIL mask0 bit%0d: SOUT=%0b want 0",
                         i, bus.SOUT);
            end
        end
        bus.EN = 1'b0;
        n_chk++;
        if (bus.MCNT !== 8'd5) begin
            n_fail++;
            $display("FAIL mask0_cnt: MCNT=%0d want 5", bus.MCNT);
        end
    endtask

    task automatic test_saturation();
        int ec;
        bus2.LOAD    = 1'b1;
        bus2.PAT_IN  = 8'hFF;
        bus2.MASK_IN = 8'hFF;
        tick();
        bus2.LOAD = 1'b0;
        bus2.OVL  = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            bus2.EN  = 1'b1;
            bus2.DIN = 1'b1;
            tick();
            ec = (k < 8) ? 0 : ((k - 7 > 3) ? 3 : k - 7);
            n_chk++;
            if (bus2.SOUT !== (k >= 8) || bus2.MCNT !== 2'(ec)) begin
                n_fail++;
                $display("FAIL sat bit%0d: SOUT=%0b MCNT=%0d want %0b %0d",
                         k, bus2.SOUT, bus2.MCNT, (k >= 8), ec);
            end
        end
        bus2.CLR_CNT = 1'b1;
        tick();
        n_chk++;
        if (bus2.SOUT !== 1'b1 || bus2.MCNT !== 2'd1) begin
            n_fail++;
            $display("FAIL clr_hit: SOUT=%0b MCNT=%0d want 1 1",
                     bus2.SOUT, bus2.MCNT);
        end
        bus2.EN = 1'b0;
        tick();
        bus2.CLR_CNT = 1'b0;
        n_chk++;
        if (bus2.SOUT !== 1'b0 || bus2.MCNT !== 2'd0) begin
            n_fail++;
            $display("FAIL clr: SOUT=%0b MCNT=%0d want 0 0",
                     bus2.SOUT, bus2.MCNT);
        end
    endtask

    task automatic test_rst_mid();
        logic [7:0] s;
        s = 8'hD3;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            bus.EN  = 1'b1;
            bus.DIN = s[i];
            tick();
        end
        RST     = 1'b1;
        bus.DIN = s[0];
        tick();
        RST = 1'b0;
        n_chk++;
        if (bus.SOUT !== 1'b0 || bus.MCNT !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid: SOUT=%0b MCNT=%0d want 0 0",
                     bus.SOUT, bus.MCNT);
        end
        tick();
        n_chk++;
        if (bus.SOUT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: SOUT=%0b want 0", bus.SOUT);
        end
        for (int i = 7; i >= 0; i--) begin
            bus.DIN = s[i];
            tick();
            n_chk++;
            if (bus.SOUT !== (i == 0)) begin
                n_fail++;
                $display("FAIL rst_refill bit%0d: SOUT=%0b want %0b",
                         8 - i, bus.SOUT, (i == 0));
            end
        end
        bus.EN = 1'b0;
        n_chk++;
        if (bus.MCNT !== 8'd1) begin
            n_fail++;
            $display("FAIL rst_cnt: MCNT=%0d want 1", bus.MCNT);
        end
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        RST          = 1'b1;
        bus.EN       = 1'b0;
        bus.DIN      = 1'b0;
        bus.OVL      = 1'b1;
        bus.LOAD     = 1'b0;
        bus.PAT_IN   = '0;
        bus.MASK_IN  = '0;
        bus.CLR_CNT  = 1'b0;
        bus2.EN      = 1'b0;
        bus2.DIN     = 1'b0;
        bus2.OVL     = 1'b1;
        bus2.LOAD    = 1'b0;
        bus2.PAT_IN  = '0;
        bus2.MASK_IN = '0;
        bus2.CLR_CNT = 1'b0;
        test_reset();
        test_default();
        test_gaps();
        test_load_mid();
        test_overlap();
        test_mask_zero();
        test_saturation();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
